// File: rtl/vx_mask_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// vx_mask_sequencer_pkg
//   Shared helpers for the mask sequencer and its priority picker.
//   log2up() gives the index width for an N-entry mask. It never returns 0,
//   so a one-bit mask still gets a one-bit index.
// ---------------------------------------------------------------------------
package vx_mask_sequencer_pkg;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_mask_pick.sv
// ---------------------------------------------------------------------------
// vx_mask_pick
//   Combinational priority pick over a mask.
//   Parameters:
//     N       - mask width
//     REVERSE - 0: pick the highest set bit, 1: pick the lowest set bit
//   Ports:
//     mask   in  [N-1:0]     candidate bits
//     idx    out [LOGN-1:0]  index of the picked bit (0 when mask is empty)
//     valid  out             mask has at least one set bit
//     single out             mask has exactly one set bit
// ---------------------------------------------------------------------------
module vx_mask_pick
  import vx_mask_sequencer_pkg::*;
#(
  parameter int N       = 8,
  parameter int REVERSE = 0,
  parameter int LOGN    = log2up(N)
) (
  input  logic [N-1:0]    mask,
  output logic [LOGN-1:0] idx,
  output logic            valid,
  output logic            single
);

  // The scan visits candidates from lowest to highest priority, so the last
  // set bit that it sees wins. In leading-zero order the scan runs upward. In
  // trailing-zero order it runs downward.
  always_comb begin
    idx = '0;
    if (REVERSE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (mask[i]) idx = LOGN'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (mask[i]) idx = LOGN'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign valid  = |mask;
  assign single = valid && ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/vx_mask_sequencer.sv
// ---------------------------------------------------------------------------
// vx_mask_sequencer
//   Accepts an N-bit request mask with a tag. It then emits the index of each
//   set bit, one per cycle, in priority order, and marks the final one.
//   Parameters:
//     N       - mask width
//     TAGW    - tag width
//     REVERSE - 0: highest index first, 1: lowest index first
//     LOGN    - index width (derived)
//   Ports:
//     clk        in   clock
//     reset      in   asynchronous active-high reset
//     flush      in   abort the sequence in progress at the next edge
//     in_valid   in   request valid
//     in_mask    in   request mask
//     in_tag     in   request tag
//     in_ready   out  request can be accepted this cycle
//     out_valid  out  out_index is valid
//     out_index  out  index of the current set bit
//     out_tag    out  tag of the request being sequenced
//     out_last   out  current index is the final set bit
//     out_ready  in   consumer accepts out_index
//     busy       out  pending mask is non-zero
// ---------------------------------------------------------------------------
module vx_mask_sequencer
  import vx_mask_sequencer_pkg::*;
#(
  parameter int N       = 8,
  parameter int TAGW    = 4,
  parameter int REVERSE = 0,
  parameter int LOGN    = log2up(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [N-1:0]    in_mask,
  input  logic [TAGW-1:0] in_tag,
  output logic            in_ready,
  output logic            out_valid,
  output logic [LOGN-1:0] out_index,
  output logic [TAGW-1:0] out_tag,
  output logic            out_last,
  input  logic            out_ready,
  output logic            busy
);

  logic [N-1:0]    pending;
  logic [TAGW-1:0] tag_r;

  logic [LOGN-1:0] pick_idx;
  logic            pick_valid;
  logic            pick_single;
  logic            out_fire;
  logic            in_fire;

  // The picker sees only registered state, so nothing on in_* reaches the
  // outputs combinationally.
  vx_mask_pick #(
    .N       (N),
    .REVERSE (REVERSE),
    .LOGN    (LOGN)
  ) u_pick (
    .mask   (pending),
    .idx    (pick_idx),
    .valid  (pick_valid),
    .single (pick_single)
  );

  assign busy      = pick_valid;
  assign out_valid = busy & ~flush;
  assign out_index = busy ? pick_idx : '0;
  assign out_tag   = tag_r;
  // Only one bit left means that removing the picked bit empties the mask.
  assign out_last  = busy & pick_single;

  assign out_fire  = out_valid & out_ready;
  // A new request can land on the same edge that retires the final index.
  // This lets sequences run back to back with no idle cycle between them.
  assign in_ready  = ~reset & ~flush & (~busy | (out_fire & out_last));
  assign in_fire   = in_valid & in_ready;

  // A new request overwrites the whole pending mask, so it takes priority
  // over retiring a bit. flush drops the rest of the sequence but keeps the
  // tag. in_fire and flush cannot happen together because flush blocks
  // in_ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      tag_r   <= '0;
    end else if (in_fire) begin
      pending <= in_mask;
      tag_r   <= in_tag;
    end else if (flush) begin
      pending <= '0;
    end else if (out_fire) begin
      pending <= pending & ~(N'(1) << pick_idx);
    end
  end

endmodule

// File: tb/tb_vx_mask_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vx_mask_sequencer
//   Directed bench for vx_mask_sequencer with N=8 and TAGW=4. A second
//   instance with REVERSE=1 shares all inputs so that both pick orders see
//   the same traffic.
// ---------------------------------------------------------------------------
module tb_vx_mask_sequencer;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_mask;
  logic [3:0] in_tag;
  logic       out_ready;

  logic       in_ready,  out_valid,  out_last,  busy;
  logic [2:0] out_index;
  logic [3:0] out_tag;

  logic       r_in_ready, r_out_valid, r_out_last, r_busy;
  logic [2:0] r_out_index;
  logic [3:0] r_out_tag;

  int errors = 0;
  int checks = 0;

  vx_mask_sequencer #(.N(8), .TAGW(4), .REVERSE(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_index (out_index),
    .out_tag   (out_tag),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy)
  );

  vx_mask_sequencer #(.N(8), .TAGW(4), .REVERSE(1)) dut_rev (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_mask   (in_mask),
    .in_tag    (in_tag),
    .in_ready  (r_in_ready),
    .out_valid (r_out_valid),
    .out_index (r_out_index),
    .out_tag   (r_out_tag),
    .out_last  (r_out_last),
    .out_ready (out_ready),
    .busy      (r_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge, and outputs are sampled 1 time unit
  // later, well before the next rising edge.
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mask = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_index, out_tag, out_last, busy} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_asserted: got %b expected all zero", {in_ready, out_valid, out_index, out_tag, out_last, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_index, out_tag, out_last, busy} !== {1'b1, 10'd0}) begin
      errors++;
      $display("[TB] FAIL reset_released: got %b expected 1 then zeros", {in_ready, out_valid, out_index, out_tag, out_last, busy});
    end
  endtask

  task automatic test_order();
    logic [2:0] exp_f [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
    logic [2:0] exp_r [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hA5; in_tag = 4'd3; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_accept: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== exp_f[b] || out_tag !== 4'd3 || out_last !== (b == 3)) begin
        errors++;
        $display("[TB] FAIL order_fwd beat %0d: got v=%b idx=%0d tag=%0d last=%b expected v=1 idx=%0d tag=3 last=%b",
                 b, out_valid, out_index, out_tag, out_last, exp_f[b], (b == 3));
      end
      checks++;
      if (r_out_valid !== 1'b1 || r_out_index !== exp_r[b] || r_out_tag !== 4'd3 || r_out_last !== (b == 3)) begin
        errors++;
        $display("[TB] FAIL order_rev beat %0d: got v=%b idx=%0d tag=%0d last=%b expected v=1 idx=%0d tag=3 last=%b",
                 b, r_out_valid, r_out_index, r_out_tag, r_out_last, exp_r[b], (b == 3));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || r_busy !== 1'b0 || r_out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL order_drained: got busy=%b/%b valid=%b/%b expected all 0", busy, r_busy, out_valid, r_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] exp_i [5] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd0};
    logic       exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h81; in_tag = 4'd5; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = (c >= 3);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== exp_i[c] || out_last !== exp_l[c] || out_tag !== 4'd5) begin
        errors++;
        $display("[TB] FAIL backpressure cycle %0d: got v=%b idx=%0d last=%b tag=%0d expected v=1 idx=%0d last=%b tag=5",
                 c, out_valid, out_index, out_last, out_tag, exp_i[c], exp_l[c]);
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL backpressure_drained: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h03; in_tag = 4'd1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd1 || out_tag !== 4'd1 || out_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_beat0: got v=%b idx=%0d tag=%0d last=%b expected v=1 idx=1 tag=1 last=0", out_valid, out_index, out_tag, out_last);
    end
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h10; in_tag = 4'd2;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd0 || out_tag !== 4'd1 || out_last !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_beat1: got v=%b idx=%0d tag=%0d last=%b rdy=%b expected v=1 idx=0 tag=1 last=1 rdy=1",
               out_valid, out_index, out_tag, out_last, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd4 || out_tag !== 4'd2 || out_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_beat2: got v=%b idx=%0d tag=%0d last=%b expected v=1 idx=4 tag=2 last=1", out_valid, out_index, out_tag, out_last);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_drained: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_zero_mask();
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'h00; in_tag = 4'd7; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_accept: got ready=%b expected 1", in_ready);
    end
    @(negedge clk);
    in_mask = 8'h40; in_tag = 4'd9;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 4'd7) begin
      errors++;
      $display("[TB] FAIL zero_idle: got busy=%b v=%b rdy=%b tag=%0d expected busy=0 v=0 rdy=1 tag=7", busy, out_valid, in_ready, out_tag);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd6 || out_last !== 1'b1 || out_tag !== 4'd9) begin
      errors++;
      $display("[TB] FAIL zero_next: got v=%b idx=%0d last=%b tag=%0d expected v=1 idx=6 last=1 tag=9", out_valid, out_index, out_last, out_tag);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_drained: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_flush();
    logic [2:0] exp_i [2] = '{3'd7, 3'd6};
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hFF; in_tag = 4'd2; out_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_index !== exp_i[b] || out_last !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_beat %0d: got v=%b idx=%0d last=%b expected v=1 idx=%0d last=0", b, out_valid, out_index, out_last, exp_i[b]);
      end
    end
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_mask = 8'h01;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_cycle: got v=%b rdy=%b busy=%b expected v=0 rdy=0 busy=1", out_valid, in_ready, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_tag !== 4'd2) begin
      errors++;
      $display("[TB] FAIL flush_idle_block: got busy=%b v=%b rdy=%b tag=%0d expected busy=0 v=0 rdy=0 tag=2", busy, out_valid, in_ready, out_tag);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_after: got busy=%b rdy=%b expected busy=0 rdy=1", busy, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_mask = 8'hFF; in_tag = 4'd6; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 3'd7 || out_tag !== 4'd6) begin
      errors++;
      $display("[TB] FAIL rst_mid_pre: got v=%b idx=%0d tag=%0d expected v=1 idx=7 tag=6", out_valid, out_index, out_tag);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, out_index, out_tag, out_last, busy} !== 11'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_async: got %b expected all zero", {in_ready, out_valid, out_index, out_tag, out_last, busy});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || r_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_after: got busy=%b v=%b rdy=%b rbusy=%b expected busy=0 v=0 rdy=1 rbusy=0", busy, out_valid, in_ready, r_busy);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_back_to_back();
    test_zero_mask();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vx_mask_sequencer.md
Name: vx_mask_sequencer

Overview:
Sequencer that accepts an N-bit request mask plus a tag, then emits the index of every set bit, one per cycle, in priority order, with a last marker. It serialises per-lane work (thread-mask splits, per-bank replays) onto a single shared port. Index selection uses a leading-zero or trailing-zero priority pick over the pending mask. Valid/ready handshakes on both sides give full back-pressure.

Parameters:
N, 8, mask width (N >= 1)
TAGW, 4, width of the opaque tag carried with each mask (>= 1)
REVERSE, 0, 0 = highest set index first (leading-zero order); 1 = lowest set index first (trailing-zero order)
LOGN, LOG2UP(N), index width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of the sequence in progress
in_valid  in  1  request mask valid
in_mask  in  N  request mask
in_tag  in  TAGW  tag for the request
in_ready  out  1  sequencer can accept a request this cycle
out_valid  out  1  out_index valid
out_index  out  LOGN  index of the current set bit
out_tag  out  TAGW  tag of the request being sequenced
out_last  out  1  out_index is the final set bit of the request
out_ready  in  1  consumer accepts out_index
busy  out  1  pending mask non-zero

Behaviour:
- State: pending[N], tag_r[TAGW]. IDLE when pending == 0, otherwise BUSY. No other state.
- Reset (async assert, sync release): pending = 0, tag_r = 0. Outputs during and after reset: out_valid = 0, out_index = 0, out_tag = 0, out_last = 0, busy = 0, in_ready = 1 (in_ready = 0 while reset is asserted).
- Pick: idx = highest set bit of pending (REVERSE=0) or lowest set bit (REVERSE=1). It is combinational from registers only. out_index = idx when BUSY, else 0.
- out_valid = BUSY & ~flush. out_tag = tag_r. out_last = BUSY & ((pending & ~onehot(idx)) == 0).
- out_fire = out_valid & out_ready. On out_fire: pending[idx] is cleared at the next edge.
- in_ready = ~flush & (IDLE | (out_fire & out_last)). This gives back-to-back sequences with zero bubble.
- in_fire = in_valid & in_ready. On in_fire: pending <= in_mask and tag_r <= in_tag. This takes priority over the out_fire bit-clear.
- Latency: a mask accepted at edge k gives its first out_valid in the cycle after edge k. Throughput is 1 index/cycle with out_ready held high. A K-bit mask drains in K cycles.
- Zero mask: accepted (in_fire), pending stays 0, no output is produced, tag_r is still updated.
- Back-pressure: while out_valid & ~out_ready, out_index, out_tag and out_last hold stable. No bit is cleared.
- Simultaneous last-fire + in_valid: the new mask is loaded on the same edge and the next cycle shows its first index.
- flush: at the next edge pending = 0 (tag_r unchanged). In the flush cycle out_valid = 0 and in_ready = 0, so no handshake completes on either side. flush while IDLE has no effect beyond blocking input for that cycle.
- Reset mid-sequence: pending clears immediately (async). No further outputs are produced.
- Single-bit mask: one output with out_last = 1.
- N == 1: idx = 0. The sequencer degenerates to a one-entry buffer with out_last = 1.
- No combinational path from in_* to out_*. in_ready depends combinationally on out_ready and flush.

Decomposition:
- Shared package: none required. LOGN is derived with the standard LOG2UP macro. No new typedefs.
- One natural sub-module: vx_mask_pick (combinational). Parameters N and REVERSE. Inputs: mask. Outputs: idx[LOGN], valid, and single (mask has exactly one set bit). It is built on the library priority/zero-count primitive. The sequencer keeps the registers and handshake logic.

Test Plan:
- N=8, REVERSE=0, mask 0xA5 tag 3, out_ready=1 -> indices 7,5,2,0 on 4 consecutive cycles, tag 3, out_last only on index 0, busy low after.
- Same mask, REVERSE=1 -> indices 0,2,5,7, out_last on 7.
- Mask 0x81; out_ready low for 3 cycles after first out_valid -> index 7 held stable 3 cycles, then 7,0 emitted; no bit lost.
- Back-to-back: 0x03 tag 1, then 0x10 tag 2 presented during the last beat -> sequence 1,0,4 with tags 1,1,2 and no idle cycle between 0 and 4.
- Zero mask 0x00, then 0x40 -> zero mask accepted with no output; next cycle index 6, last=1.
- Mask 0xFF, flush after 2 beats -> outputs 7,6; out_valid low in flush cycle; busy low next cycle. Separately, assert reset mid-0xFF -> out_valid drops immediately and all outputs are 0.
